// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern-detection controller.
// Software programs a pattern, its length, overlap mode and a match target
// through a valid/ready config port. The block then runs detection on a
// qualified single-bit stream, counting matches and entering DONE when the
// target is reached (target 0 = run until abort/reconfig/reset).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_valid / cfg_ready     config handshake (ready whenever not in RUN)
//   cfg_pattern, cfg_len      pattern (bit [len-1] received first) and length
//   cfg_overlap, cfg_target   overlap mode, matches needed for done (0 = none)
//   cfg_err                   one-cycle pulse: config rejected (bad length)
//   start, abort              begin/restart detection, stop back to ARMED
//   in, in_valid              serial data bit and its qualifier
//   busy, match, match_count  RUN indicator, per-match pulse, match counter
//   done                      high while in DONE
module seq_detect_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic [CNT_W-1:0]           cfg_target,
    output logic                       cfg_err,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       in,
    input  logic                       in_valid,
    output logic                       busy,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic                       done
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   window_q, window_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PAT_W-1:0]   len_mask;
    logic [PAT_W-1:0]   win_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cfg_len_ok;
    logic               hit;

    // Mask selecting the low len_q bits of window and pattern
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Datapath helpers evaluated on the post-shift values
    always_comb begin
        win_shift  = {window_q[PAT_W-2:0], in};
        fill_inc   = (fill_q < LEN_W'(PAT_W)) ? fill_q + LEN_W'(1) : fill_q;
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        hit        = (fill_inc >= len_q) && ((win_shift & len_mask) == (pat_q & len_mask));
        cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        unique case (state_q)
            S_RUN: begin
                // abort wins over a bit that would complete the pattern
                if (abort) begin
                    state_d = S_ARMED;
                end else if (in_valid) begin
                    window_d = win_shift;
                    fill_d   = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                // IDLE / ARMED / DONE: config port open; a handshake drops start
                if (cfg_valid) begin
                    if (cfg_len_ok) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        tgt_d   = cfg_target;
                        state_d = S_ARMED;
                        if (state_q == S_DONE) begin
                            cnt_d = '0;
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (start && (state_q != S_IDLE)) begin
                    state_d  = S_RUN;
                    window_d = '0;
                    fill_d   = '0;
                    cnt_d    = '0;
                end
            end
        endcase

        cfg_ready_d = (state_d != S_RUN);
        busy_d      = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            window_q    <= '0;
            fill_q      <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            match_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            fill_q      <= fill_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign busy        = busy_q;
    assign match       = match_q;
    assign match_count = cnt_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed table-driven bench for seq_detect_ctrl (PAT_W=8, CNT_W=8).
module tb_seq_detect_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             din;
    logic             in_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .in          (din),
        .in_valid    (in_valid),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done)
    );

    typedef struct {
        int               test;
        logic             rst;
        logic             cv;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ovl;
        logic [CNT_W-1:0] tgt;
        logic             st;
        logic             ab;
        logic             d;
        logic             dv;
        logic             e_rdy;
        logic             e_err;
        logic             e_bsy;
        logic             e_mat;
        logic [CNT_W-1:0] e_cnt;
        logic             e_dn;
    } vec_t;

    vec_t vecs[$];
    int   cur_test;

    // Generic vector: inputs then expected {ready, err, busy, match, count, done}
    task automatic v(input logic r, input logic cv, input logic [PAT_W-1:0] pat,
                     input logic [LEN_W-1:0] len, input logic ovl, input logic [CNT_W-1:0] tgt,
                     input logic st, input logic ab, input logic d, input logic dv,
                     input logic rdy, input logic err, input logic bsy, input logic mat,
                     input logic [CNT_W-1:0] cnt, input logic dn);
        vec_t x;
        x.test = cur_test; x.rst = r; x.cv = cv; x.pat = pat; x.len = len; x.ovl = ovl;
        x.tgt = tgt; x.st = st; x.ab = ab; x.d = d; x.dv = dv;
        x.e_rdy = rdy; x.e_err = err; x.e_bsy = bsy; x.e_mat = mat; x.e_cnt = cnt; x.e_dn = dn;
        vecs.push_back(x);
    endtask

    // Bit in RUN that leaves the block in RUN
    task automatic rb(input logic d, input logic dv, input logic mat, input logic [CNT_W-1:0] cnt);
        v(0, 0, 0, 0, 0, 0, 0, 0, d, dv, 0, 0, 1, mat, cnt, 0);
    endtask

    // Config request; expected outputs given by caller
    task automatic cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl,
                       input logic [CNT_W-1:0] tgt, input logic st,
                       input logic rdy, input logic err, input logic bsy, input logic [CNT_W-1:0] cnt,
                       input logic dn);
        v(0, 1, pat, len, ovl, tgt, st, 0, 0, 0, rdy, err, bsy, 0, cnt, dn);
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; cfg_valid = x.cv; cfg_pattern = x.pat; cfg_len = x.len;
        cfg_overlap = x.ovl; cfg_target = x.tgt; start = x.st; abort = x.ab;
        din = x.d; in_valid = x.dv;
    endtask

    task automatic check(input string name, input int idx,
                         input logic rdy, input logic err, input logic bsy, input logic mat,
                         input logic [CNT_W-1:0] cnt, input logic dn);
        checks++;
        if ({cfg_ready, cfg_err, busy, match, match_count, done} !== {rdy, err, bsy, mat, cnt, dn}) begin
            errors++;
            $display("FAIL %s %0d: got rdy=%b err=%b busy=%b match=%b cnt=%0d done=%b, expected rdy=%b err=%b busy=%b match=%b cnt=%0d done=%b",
                     name, idx, cfg_ready, cfg_err, busy, match, match_count, done,
                     rdy, err, bsy, mat, cnt, dn);
        end
    endtask

    initial begin
        vec_t idle_v;
        int   model_cnt;
        logic bit_v;

        idle_v = '{default: '0};
        drive(idle_v);

        // 1: 101, overlap, unlimited
        cur_test = 1;
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        cfg(8'b101, 3, 1, 0, 0,          1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        rb(1, 1, 0, 0); rb(0, 1, 0, 0); rb(1, 1, 1, 1); rb(0, 1, 0, 1); rb(1, 1, 1, 2);
        rb(1, 0, 0, 2);

        // 2: same stream, no overlap
        cur_test = 2;
        v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 2, 0);
        cfg(8'b101, 3, 0, 0, 0,          1, 0, 0, 2, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        rb(1, 1, 0, 0); rb(0, 1, 0, 0); rb(1, 1, 1, 1); rb(0, 1, 0, 1); rb(1, 1, 0, 1);

        // 3: 1101, no overlap, target 2, alternate invalid cycles carry noise
        cur_test = 3;
        v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0);
        cfg(8'b1101, 4, 0, 2, 0,         1, 0, 0, 1, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        rb(1, 1, 0, 0); rb(0, 0, 0, 0); rb(1, 1, 0, 0); rb(0, 0, 0, 0);
        rb(0, 1, 0, 0); rb(1, 0, 0, 0); rb(1, 1, 1, 1); rb(0, 0, 0, 1);
        rb(1, 1, 0, 1); rb(0, 0, 0, 1); rb(1, 1, 0, 1); rb(0, 0, 0, 1);
        rb(0, 1, 0, 1); rb(1, 0, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 1, 2, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 2, 1);
        v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  1, 0, 0, 0, 2, 1);
        // handshake in DONE clears done/count and drops the simultaneous start
        cfg(8'b101, 3, 1, 0, 1,          1, 0, 0, 0, 0);

        // 5: config blocked in RUN, abort beats a completing bit
        cur_test = 5;
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        rb(1, 1, 0, 0); rb(0, 1, 0, 0); rb(1, 1, 1, 1);
        v(0, 1, 8'b0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0);
        rb(0, 1, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  1, 0, 0, 0, 1, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        rb(1, 1, 0, 0); rb(0, 1, 0, 0); rb(1, 1, 1, 1);

        // 6: reset mid-RUN after 2 matches discards config
        cur_test = 6;
        rb(0, 1, 0, 1); rb(1, 1, 1, 2);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);

        // 4: illegal lengths, then full-width pattern with target 1
        cur_test = 4;
        cfg(8'h5A, 0, 0, 0, 0,           1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        cfg(8'h5A, 9, 0, 0, 0,           1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        cfg(8'hA5, 8, 0, 1, 0,           1, 0, 0, 0, 0);
        cfg(8'h00, 0, 0, 0, 0,           1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        rb(1, 1, 0, 0); rb(0, 1, 0, 0); rb(1, 1, 0, 0); rb(0, 1, 0, 0);
        rb(0, 1, 0, 0); rb(1, 1, 0, 0); rb(0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 1, 1, 1);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec(test%0d)", vecs[i].test), i,
                  vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_bsy, vecs[i].e_mat,
                  vecs[i].e_cnt, vecs[i].e_dn);
        end

        // len=1 pattern 1, no overlap, unlimited: every 1 matches, count saturates at 255
        idle_v.rst = 1'b1;
        drive(idle_v);
        @(posedge clk); #1;
        idle_v.rst = 1'b0;
        idle_v.cv = 1'b1; idle_v.pat = 8'h01; idle_v.len = 1;
        drive(idle_v);
        @(posedge clk); #1;
        check("len1_cfg", 0, 1, 0, 0, 0, 0, 0);
        idle_v.cv = 1'b0; idle_v.st = 1'b1;
        drive(idle_v);
        @(posedge clk); #1;
        check("len1_start", 0, 0, 0, 1, 0, 0, 0);
        idle_v.st = 1'b0; idle_v.dv = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            bit_v = ((i % 7) != 3);
            idle_v.d = bit_v;
            drive(idle_v);
            @(posedge clk); #1;
            if (bit_v && model_cnt < 255) model_cnt++;
            check("len1_sat", i, 0, 0, 1, bit_v, CNT_W'(model_cnt), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Configurable serial pattern-detection controller for the single-bit stream detectors.
- Accepts a pattern, length, overlap mode and match target over a valid/ready config port.
- Arms, runs and stops detection on a qualified serial input, counting matches.
- Asserts done when the programmed number of matches is reached.
- Replaces fixed-pattern detectors wherever software-selectable patterns are needed.

Parameters:
PAT_W, 8, maximum pattern length in bits (legal 2..16).
CNT_W, 8, width of the match counter and the target.

Ports:
clk  input  1  clock, all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
cfg_valid  input  1  config request.
cfg_ready  output  1  config can be accepted this cycle.
cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last.
cfg_len  input  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W.
cfg_overlap  input  1  1 = overlapping matches allowed.
cfg_target  input  CNT_W  matches needed before done; 0 = unlimited.
cfg_err  output  1  one-cycle pulse: config rejected (illegal length).
start  input  1  begin or restart detection.
abort  input  1  stop detection and return to ARMED.
in  input  1  serial data bit.
in_valid  input  1  in is sampled only when high.
busy  output  1  high in RUN.
match  output  1  one-cycle pulse per detected pattern.
match_count  output  CNT_W  matches since the last start.
done  output  1  high while in DONE.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; shift window and fill counter cleared; config registers cleared.
- Output reset values: cfg_ready=1, cfg_err=0, busy=0, match=0, match_count=0, done=0.
- Reset mid-RUN discards the configuration.
- States: IDLE (no config), ARMED (config held), RUN, DONE.
- cfg_ready = (state != RUN). A handshake occurs when cfg_valid && cfg_ready.
  - cfg_len in 1..PAT_W: config registers load; next state ARMED. In DONE this also clears done and match_count.
  - cfg_len = 0 or > PAT_W: nothing loads, state unchanged, cfg_err pulses the next cycle.
- start in ARMED or DONE (with no config handshake that cycle) -> RUN.
  - The same edge clears the window, fill counter and match_count.
  - start in IDLE or RUN is ignored.
  - A handshake has priority over start in the same cycle; that start is dropped.
- RUN, edge with in_valid=1:
  - window <= {window[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
  - Match condition on the updated values: fill >= cfg_len and window[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
- RUN, in_valid=0: no state change, match=0.
- On a match:
  - match=1 for exactly the cycle after the sampling edge (registered, latency 1).
  - match_count increments on that same edge and saturates at all-ones.
  - cfg_overlap=0: fill resets to 0, so the next match needs cfg_len fresh bits.
  - cfg_overlap=1: fill is retained.
- Done: if cfg_target != 0 and the incremented count == cfg_target, the state goes RUN -> DONE on the same edge.
  - done=1 and busy=0 from the next cycle, together with the final match pulse.
- abort in RUN -> ARMED next edge. match_count is held and no match is issued that edge, even if the sampled bit completes the pattern.
  - abort has priority over a completing bit.
  - abort is ignored outside RUN.
- DONE holds match_count and ignores in/in_valid until start, a config handshake, or rst.
- cfg_len = 1: every valid bit equal to cfg_pattern[0] matches; overlap is irrelevant.

Test Plan:
1. Pattern 3'b101, len 3, overlap=1, target 0; start, then bits 1,0,1,0,1 on consecutive valid cycles -> match pulses after the 3rd and 5th bits; match_count=2; busy stays 1.
2. Same stream with overlap=0 -> a single match after the 3rd bit; match_count=1.
3. Pattern 4'b1101, len 4, overlap=0, target 2; stream 1101_1101 with in_valid low on alternate cycles -> matches after valid bits 4 and 8; done=1 in the cycle after bit 8; further bits leave match_count=2.
4. cfg_len=0, then cfg_len=PAT_W+1 -> cfg_err pulses once each; state stays IDLE; start is ignored (busy=0).
5. In RUN, assert cfg_valid -> cfg_ready=0, no load. Assert abort on the edge where 1,0,1 completes -> no match, ARMED next cycle. start -> match_count=0, detection resumes.
6. rst asserted mid-RUN after 2 matches -> the next cycle shows all outputs at reset values and state IDLE; start without reconfig is ignored.
